// File: rtl/aes_req_arbiter.sv
// Round-robin front end that shares one AES core among NREQ requesters.
// It grants one job at a time, runs the core with a watchdog and returns the tagged result.
module aes_req_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*128-1:0] req_key,
  input  logic [NREQ*128-1:0] req_text,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [127:0]        rsp_text,
  output logic                rsp_err,
  output logic                busy,
  output logic                core_ld,
  output logic [127:0]        core_key,
  output logic [127:0]        core_text_in,
  input  logic                core_done,
  input  logic [127:0]        core_text_out
);

  localparam int unsigned DW  = 128;
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   rr_last;
  logic [WDW-1:0]   wdog;

  logic [IDW-1:0]   win;
  logic             win_vld;
  logic [DW-1:0]    sel_key;
  logic [DW-1:0]    sel_text;
  logic [NREQ-1:0]  grant;
  logic             take;
  logic             done_hit;
  logic             wd_hit;
  logic             rsp_hs;

  // Round-robin search: indices above rr_last first, then wrap to 0..rr_last.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int j = 0; j < int'(NREQ); j++) begin
      if (!win_vld && req_valid[j] && (IDW'(j) > rr_last)) begin
        win     = IDW'(j);
        win_vld = 1'b1;
      end
    end
    for (int j = 0; j < int'(NREQ); j++) begin
      if (!win_vld && req_valid[j] && (IDW'(j) <= rr_last)) begin
        win     = IDW'(j);
        win_vld = 1'b1;
      end
    end
  end

  // Payload mux for the winning requester.
  always_comb begin
    sel_key  = '0;
    sel_text = '0;
    for (int j = 0; j < int'(NREQ); j++) begin
      if (IDW'(j) == win) begin
        sel_key  = req_key[j*DW +: DW];
        sel_text = req_text[j*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; done beats the watchdog when both land together.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    done_hit  = 1'b0;
    wd_hit    = 1'b0;
    rsp_hs    = 1'b0;
    grant     = '0;
    case (state)
      S_IDLE: begin
        if (win_vld && !rst) begin
          take      = 1'b1;
          grant     = NREQ'(1) << win;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (core_done) begin
          done_hit  = 1'b1;
          state_nxt = S_RESP;
        end else if (wdog == WDW'(TIMEOUT - 1)) begin
          wd_hit    = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_hs    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign req_ready = grant;

  // Registered outputs follow the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_ld   <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      core_ld   <= (state_nxt == S_LOAD);
      busy      <= (state_nxt != S_IDLE);
      rsp_valid <= (state_nxt == S_RESP);
    end
  end

  // Job capture: payload and owner id are frozen until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_key     <= '0;
      core_text_in <= '0;
      rsp_id       <= '0;
    end else if (take) begin
      core_key     <= sel_key;
      core_text_in <= sel_text;
      rsp_id       <= win;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog <= '0;
    end else if (state == S_LOAD) begin
      wdog <= '0;
    end else if (state == S_RUN) begin
      wdog <= wdog + WDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_text <= '0;
      rsp_err  <= 1'b0;
    end else if (done_hit) begin
      rsp_text <= core_text_out;
      rsp_err  <= 1'b0;
    end else if (wd_hit) begin
      rsp_text <= '0;
      rsp_err  <= 1'b1;
    end
  end

  // Priority pointer advances only once the response is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last <= IDW'(NREQ - 1);
    end else if (rsp_hs) begin
      rr_last <= rsp_id;
    end
  end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter with a 12-cycle XOR core model.
module tb_aes_req_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*128-1:0] req_key;
  logic [NREQ*128-1:0] req_text;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [127:0]        rsp_text;
  logic                rsp_err;
  logic                busy;
  logic                core_ld;
  logic [127:0]        core_key;
  logic [127:0]        core_text_in;
  logic                core_done;
  logic [127:0]        core_text_out;

  logic                model_en;
  logic                model_done;
  logic                inj_done;
  logic [127:0]        model_res;
  int                  cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] key_a  [NREQ];
  logic [127:0] text_a [NREQ];

  aes_req_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(31)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_text(req_text),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_text(rsp_text), .rsp_err(rsp_err),
    .busy(busy), .core_ld(core_ld),
    .core_key(core_key), .core_text_in(core_text_in),
    .core_done(core_done), .core_text_out(core_text_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: done exactly 12 cycles after ld is sampled, result key^text.
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (core_ld && model_en) begin
      cnt       <= 11;
      model_res <= core_key ^ core_text_in;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) model_done <= 1'b1;
    end
  end

  assign core_done     = model_done | inj_done;
  assign core_text_out = model_res;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete job, entered at a sampled negedge, left at the IDLE bubble after handshake.
  task automatic run_job(input int exp_id, input logic exp_err, input int exp_lat,
                         input int hold, input logic [NREQ-1:0] valid_after);
    int n;
    logic [127:0] exp_text;
    logic [127:0] held;
    exp_text = exp_err ? 128'h0 : (key_a[exp_id] ^ text_a[exp_id]);
    n = 0;
    while (req_ready == '0 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("grant", 128'(req_ready), 128'(NREQ'(1) << exp_id));
    @(negedge clk);
    req_valid = valid_after;
    #1;
    chk("core_ld", 128'(core_ld), 128'd1);
    chk("busy_run", 128'(busy), 128'd1);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk("latency", 128'(n), 128'(exp_lat));
    chk("rsp_id", 128'(rsp_id), 128'(exp_id));
    chk("rsp_text", rsp_text, exp_text);
    chk("rsp_err", 128'(rsp_err), 128'(exp_err));
    held = rsp_text;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk); #1;
      chk("hold_valid", 128'(rsp_valid), 128'd1);
      chk("hold_text", rsp_text, held);
      chk("hold_ready", 128'(req_ready), 128'd0);
      chk("hold_ld", 128'(core_ld), 128'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("rsp_drop", 128'(rsp_valid), 128'd0);
    chk("bubble_idle", 128'(busy), 128'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic seen;
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    model_en = 1'b1; inj_done = 1'b0; cnt = 0; model_res = '0;
    key_a[0] = 128'h0;
    text_a[0] = 128'h1;
    for (int i = 1; i < int'(NREQ); i++) begin
      key_a[i]  = {4{32'hC0DE_0000 + 32'(i)}};
      text_a[i] = {4{32'h1234_5670 + 32'(i * 3)}};
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      req_key[i*128 +: 128]  = key_a[i];
      req_text[i*128 +: 128] = text_a[i];
    end

    do_reset();
    chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_core_ld", 128'(core_ld), 128'd0);
    chk("rst_req_ready", 128'(req_ready), 128'd0);
    chk("rst_rsp_id", 128'(rsp_id), 128'd0);
    chk("rst_core_key", core_key, 128'd0);

    // 1: single request from requester 0
    @(negedge clk); req_valid = 4'b0001; #1;
    run_job(0, 1'b0, 13, 0, 4'b0000);

    // 2: all requesting from fresh reset -> 0,1,2,3,0
    do_reset();
    req_valid = 4'b1111; #1;
    run_job(0, 1'b0, 13, 0, 4'b1111);
    run_job(1, 1'b0, 13, 0, 4'b1111);
    run_job(2, 1'b0, 13, 0, 4'b1111);
    run_job(3, 1'b0, 13, 0, 4'b1111);
    run_job(0, 1'b0, 13, 0, 4'b0000);

    // 3: rr_last=0 with 0101 -> 2, 0, 2
    @(negedge clk); req_valid = 4'b0101; #1;
    run_job(2, 1'b0, 13, 0, 4'b0101);
    run_job(0, 1'b0, 13, 0, 4'b0101);
    run_job(2, 1'b0, 13, 0, 4'b0000);

    // 4: core never answers -> watchdog abort, then a normal job
    model_en = 1'b0;
    @(negedge clk); req_valid = 4'b0010; #1;
    run_job(1, 1'b1, 32, 0, 4'b0000);
    model_en = 1'b1;
    @(negedge clk); req_valid = 4'b1000; #1;
    run_job(3, 1'b0, 13, 0, 4'b0000);

    // 5: consumer stalls 20 cycles while others are waiting
    @(negedge clk); req_valid = 4'b0001; #1;
    run_job(0, 1'b0, 13, 20, 4'b0110);
    run_job(1, 1'b0, 13, 0, 4'b0000);

    // 6: reset in RUN, spurious done while idle, then a clean job
    @(negedge clk); req_valid = 4'b0100; #1;
    chk("t6_grant", 128'(req_ready), 128'(4'b0100));
    @(negedge clk); req_valid = 4'b0000; #1;
    chk("t6_core_ld", 128'(core_ld), 128'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_busy", 128'(busy), 128'd0);
    chk("t6_core_ld_after_rst", 128'(core_ld), 128'd0);
    seen = 1'b0;
    for (int k = 0; k < 16; k++) begin
      inj_done = (k == 2);
      @(negedge clk); #1;
      seen = seen | rsp_valid | busy;
    end
    inj_done = 1'b0;
    chk("t6_no_rsp", 128'(seen), 128'd0);
    req_valid = 4'b0100; #1;
    run_job(2, 1'b0, 13, 0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
